tff_counter_ctrl: RTL and testbench
===================================

Name: tff_counter_ctrl

Overview:
Sequencing controller for a bank of WIDTH T flip-flops used as a programmable modulo counter.
- An FSM computes the per-bit toggle vector each cycle to count, pause, reload or wrap.
- Used as the timing and sequence generator wherever a T-FF counter stage is needed in the design.
- All count state lives in the T-FF bank. The controller only drives toggle inputs and tracks mode.

Parameters:
WIDTH, 4, number of T flip-flops and count width (legal range 2..16).

Ports:
clk       input   1      rising-edge clock
reset     input   1      synchronous, active-high reset
start     input   1      begin a run from IDLE or DONE; resume from PAUSE
stop      input   1      pause from RUN; abort to IDLE from PAUSE
up_dn     input   1      1 = count up, 0 = count down; sampled on start in IDLE/DONE only
one_shot  input   1      1 = stop at terminal count, 0 = wrap; sampled with up_dn
mod_val   input   WIDTH  terminal/reload value; sampled with up_dn, ignored otherwise
count     output  WIDTH  T-FF bank q outputs
tc        output  1      terminal count flag
busy      output  1      high in RUN or PAUSE
done      output  1      high in DONE

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset. Reset overrides every other input.
- Reset values: count=0, state=IDLE, tc=0, busy=0, done=0. Latched mode and mod_val registers are cleared to 0.
- Count updates only through toggles: next_q = q ^ tog. The controller never loads q directly, except that reset clears the cells synchronously.
- Latched values: start_val = up ? 0 : mod_val_l; term_val = up ? mod_val_l : 0.
- Toggle vector:
  - Reload: tog = q ^ start_val.
  - Up increment: tog[0]=1; tog[i] = &q[i-1:0].
  - Down decrement: tog[0]=1; tog[i] = ~|q[i-1:0].
  - Hold: tog = 0.
- FSM states: IDLE, RUN, PAUSE, DONE.
  - IDLE: hold count. On start, latch up_dn, one_shot and mod_val; reload; go to RUN. count equals start_val one cycle after start.
  - RUN, stop=1: hold; go to PAUSE. stop has priority over start and over terminal.
  - RUN, count!=term_val: increment or decrement by one per cycle.
  - RUN, count==term_val, one_shot=0: reload; stay in RUN (wrap).
  - RUN, count==term_val, one_shot=1: hold; go to DONE.
  - PAUSE: hold. stop → IDLE with count held. start (without stop) → RUN, counting resumes next cycle.
  - DONE: hold, done=1. start → relatch and reload as in IDLE, go to RUN.
- tc is combinational from registered state: tc = (state==RUN) && (count==term_val). It is a one-cycle pulse per terminal visit.
- Boundaries:
  - mod_val=0: tc=1 every RUN cycle and count stays 0.
  - Up with mod_val=2^WIDTH-1 wraps 15→0 through the natural all-bit toggle (WIDTH=4).
  - mod_val changes while busy are ignored.
  - start held high in RUN has no effect.
  - Reset mid-run: count=0 and IDLE on the next edge.

Decomposition:
- Package tff_ctrl_pkg holds the state enum (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3) and the toggle-select encoding (HOLD, INC, DEC, RELOAD).
- One sub-module, tff_cell: a single T flip-flop with ports clk, reset (synchronous, active-high), t, q, qb. It is instantiated WIDTH times via generate; qb is left unused.
- The controller contains the FSM, the latch registers and the toggle-vector logic.

Test Plan:
- Reset dominance: reset=1 with start=1 for 2 cycles → count=0, busy=0, done=0, tc=0. After release, IDLE holds count=0.
- Up wrap: up_dn=1, one_shot=0, mod_val=5, start pulse → count 0,1,2,3,4,5,0,1…; tc=1 only on the cycles count=5; busy=1 throughout.
- Down one-shot: up_dn=0, one_shot=1, mod_val=3 → count 3,2,1,0 with tc=1 at 0. Next cycle done=1, busy=0, count holds 0. A second start reruns 3,2,1,0.
- Pause/abort: stop while count=2 (up, mod_val=9) → count holds 2 for 5 cycles. start → next cycle count=3. Then stop in RUN and stop again in PAUSE → IDLE, count stays at its held value, busy=0.
- Priority/edge cases:
  - start=stop=1 in RUN → PAUSE.
  - mod_val=0 up → tc=1 every RUN cycle.
  - mod_val=15 up → 15→0 wrap; changing mod_val mid-run has no effect.
- Reset mid-run: assert reset at count=4 → next edge count=0, IDLE, tc=0.

Source files
------------

// File: rtl/tff_ctrl_pkg.sv
// Shared definitions for the T-FF counter controller.
//   state_e    : controller FSM states
//   tog_sel_e  : which toggle vector the controller applies this cycle
//   tog_vec    : helper that builds the per-bit toggle vector for a selection
package tff_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    INC    = 2'd1,
    DEC    = 2'd2,
    RELOAD = 2'd3
  } tog_sel_e;

  localparam int unsigned MAX_WIDTH = 16;

  // Toggle vector for a T-FF bank currently holding q. Only the low
  // 'width' bits are meaningful; upper bits stay zero.
  function automatic logic [MAX_WIDTH-1:0] tog_vec(
    input tog_sel_e              sel,
    input logic [MAX_WIDTH-1:0]  q,
    input logic [MAX_WIDTH-1:0]  start_val,
    input int unsigned           width
  );
    logic [MAX_WIDTH-1:0] t;
    logic                 all_one;
    logic                 all_zero;
    t        = '0;
    all_one  = 1'b1;
    all_zero = 1'b1;
    unique case (sel)
      HOLD:   t = '0;
      RELOAD: t = q ^ start_val;
      INC, DEC: begin
        // Bit i toggles when every lower bit is 1 (up) or 0 (down).
        for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
          if (i < width) begin
            t[i] = (sel == INC) ? all_one : all_zero;
          end
          all_one  = all_one  & q[i];
          all_zero = all_zero & ~q[i];
        end
      end
      default: t = '0;
    endcase
    for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
      if (i >= width) t[i] = 1'b0;
    end
    return t;
  endfunction

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop with synchronous active-high reset.
//   clk   : rising-edge clock
//   reset : synchronous clear, active high
//   t     : toggle enable
//   q     : stored bit
//   qb    : complement of q
module tff_cell (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q,
  output logic qb
);

  logic q_q;

  always_ff @(posedge clk) begin
    if (reset) q_q <= 1'b0;
    else       q_q <= q_q ^ t;
  end

  assign q  = q_q;
  assign qb = ~q_q;

endmodule

// File: rtl/tff_counter_ctrl.sv
// Sequencing controller for a bank of WIDTH T flip-flops forming a
// programmable modulo counter. The controller never loads the count
// directly; every change is expressed as a toggle vector on the bank.
//   clk, reset : clock, synchronous active-high reset
//   start      : begin a run (IDLE/DONE) or resume (PAUSE)
//   stop       : pause from RUN, abort to IDLE from PAUSE
//   up_dn      : count direction, latched on start from IDLE/DONE
//   one_shot   : stop at terminal (1) or wrap (0), latched with up_dn
//   mod_val    : terminal/reload value, latched with up_dn
//   count      : T-FF bank outputs
//   tc         : terminal count flag (RUN and count == term_val)
//   busy       : RUN or PAUSE
//   done       : DONE
module tff_counter_ctrl
  import tff_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             up_dn,
  input  logic             one_shot,
  input  logic [WIDTH-1:0] mod_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  state_e             state_q, state_d;
  logic               up_q, up_d;
  logic               os_q, os_d;
  logic [WIDTH-1:0]   mod_q, mod_d;
  tog_sel_e           sel;
  logic [WIDTH-1:0]   tog;
  logic [WIDTH-1:0]   start_val;
  logic [WIDTH-1:0]   term_val;
  logic               at_term;

  logic [MAX_WIDTH-1:0] q_ext, sv_ext, tog_ext;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      up_q    <= 1'b0;
      os_q    <= 1'b0;
      mod_q   <= '0;
    end else begin
      state_q <= state_d;
      up_q    <= up_d;
      os_q    <= os_d;
      mod_q   <= mod_d;
    end
  end

  assign term_val = up_q ? mod_q : '0;
  assign at_term  = (count == term_val);

  always_comb begin
    state_d = state_q;
    up_d    = up_q;
    os_d    = os_q;
    mod_d   = mod_q;
    sel     = HOLD;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          up_d    = up_dn;
          os_d    = one_shot;
          mod_d   = mod_val;
          sel     = RELOAD;
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = PAUSE;
        end else if (at_term) begin
          if (os_q) state_d = DONE;
          else      sel     = RELOAD;
        end else begin
          sel = up_q ? INC : DEC;
        end
      end
      PAUSE: begin
        if (stop)       state_d = IDLE;
        else if (start) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reload from IDLE/DONE must use the values being latched this cycle,
  // so start_val comes from the next-state latch values (equal to the
  // current ones on a RUN wrap).
  assign start_val = up_d ? '0 : mod_d;

  always_comb begin
    q_ext            = '0;
    sv_ext           = '0;
    q_ext[WIDTH-1:0]  = count;
    sv_ext[WIDTH-1:0] = start_val;
    tog_ext          = tog_vec(sel, q_ext, sv_ext, WIDTH);
    tog              = tog_ext[WIDTH-1:0];
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bank
    tff_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .t     (tog[i]),
      .q     (count[i]),
      .qb    ()
    );
  end

  assign tc   = (state_q == RUN) && at_term;
  assign busy = (state_q == RUN) || (state_q == PAUSE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_tff_counter_ctrl.sv
module tb_tff_counter_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, stop, up_dn, one_shot;
  logic [3:0] mod_val;
  logic [3:0] count;
  logic       tc, busy, done;

  int vectors = 0;
  int miscompares = 0;

  tff_counter_ctrl #(.WIDTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .up_dn    (up_dn),
    .one_shot (one_shot),
    .mod_val  (mod_val),
    .count    (count),
    .tc       (tc),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] c, input logic t,
                         input logic b, input logic d);
    chk({tag, ".count"}, {12'b0, count}, {12'b0, c});
    chk({tag, ".tc"},    {15'b0, tc},    {15'b0, t});
    chk({tag, ".busy"},  {15'b0, busy},  {15'b0, b});
    chk({tag, ".done"},  {15'b0, done},  {15'b0, d});
  endtask

  initial begin
    logic [3:0] exp_c;

    // Reset dominance
    reset = 1; start = 1; stop = 0; up_dn = 1; one_shot = 0; mod_val = 4'd5;
    step(); chk_all("rst1", 4'd0, 0, 0, 0);
    step(); chk_all("rst2", 4'd0, 0, 0, 0);
    reset = 0; start = 0;
    step(); chk_all("idle", 4'd0, 0, 0, 0);
    step(); chk_all("idle2", 4'd0, 0, 0, 0);

    // Up wrap, mod 5
    up_dn = 1; one_shot = 0; mod_val = 4'd5; start = 1;
    step(); chk_all("upw_start", 4'd0, 0, 1, 0);
    start = 0;
    exp_c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      exp_c = (exp_c == 4'd5) ? 4'd0 : exp_c + 4'd1;
      step(); chk_all("upw", exp_c, exp_c == 4'd5, 1, 0);
    end
    // exp_c now 2: stop, stop -> IDLE
    stop = 1;
    step(); chk_all("upw_pause", 4'd2, 0, 1, 0);
    step(); chk_all("upw_abort", 4'd2, 0, 0, 0);
    stop = 0;

    // Down one-shot, mod 3, run twice
    for (int r = 0; r < 2; r++) begin
      up_dn = 0; one_shot = 1; mod_val = 4'd3; start = 1;
      step(); chk_all("dn_start", 4'd3, 0, 1, 0);
      start = 0;
      step(); chk_all("dn2", 4'd2, 0, 1, 0);
      step(); chk_all("dn1", 4'd1, 0, 1, 0);
      step(); chk_all("dn0", 4'd0, 1, 1, 0);
      step(); chk_all("dn_done", 4'd0, 0, 0, 1);
      step(); chk_all("dn_done2", 4'd0, 0, 0, 1);
    end

    // Pause / resume / abort, up mod 9
    up_dn = 1; one_shot = 0; mod_val = 4'd9; start = 1;
    step(); chk_all("pa_start", 4'd0, 0, 1, 0);
    start = 0;
    step(); chk_all("pa1", 4'd1, 0, 1, 0);
    step(); chk_all("pa2", 4'd2, 0, 1, 0);
    stop = 1;
    step(); chk_all("pa_stop", 4'd2, 0, 1, 0);
    stop = 0;
    for (int i = 0; i < 5; i++) begin
      step(); chk_all("pa_hold", 4'd2, 0, 1, 0);
    end
    start = 1;
    step(); chk_all("pa_resume", 4'd2, 0, 1, 0);
    step(); chk_all("pa3_start_held", 4'd3, 0, 1, 0);
    step(); chk_all("pa4_start_held", 4'd4, 0, 1, 0);
    stop = 1; // start=stop=1 in RUN -> PAUSE
    step(); chk_all("pa_both", 4'd4, 0, 1, 0);
    start = 0;
    step(); chk_all("pa_abort", 4'd4, 0, 0, 0);
    stop = 0;
    step(); chk_all("pa_idle", 4'd4, 0, 0, 0);

    // mod_val = 0, up: tc every RUN cycle
    up_dn = 1; one_shot = 0; mod_val = 4'd0; start = 1;
    step(); chk_all("m0_start", 4'd0, 1, 1, 0);
    start = 0;
    for (int i = 0; i < 3; i++) begin
      step(); chk_all("m0_run", 4'd0, 1, 1, 0);
    end
    stop = 1;
    step(); chk_all("m0_pause", 4'd0, 0, 1, 0);
    step(); chk_all("m0_abort", 4'd0, 0, 0, 0);
    stop = 0;

    // mod_val = 15, up: natural 15->0 wrap; mid-run mod_val change ignored
    up_dn = 1; one_shot = 0; mod_val = 4'd15; start = 1;
    step(); chk_all("m15_start", 4'd0, 0, 1, 0);
    start = 0; mod_val = 4'd3;
    exp_c = 4'd0;
    for (int i = 0; i < 17; i++) begin
      exp_c = exp_c + 4'd1;
      step(); chk_all("m15", exp_c, exp_c == 4'd15, 1, 0);
    end
    // exp_c now 1; run to 4 then reset
    step(); step(); step();
    chk_all("pre_rst", 4'd4, 0, 1, 0);
    reset = 1;
    step(); chk_all("rst_mid", 4'd0, 0, 0, 0);
    reset = 0;
    step(); chk_all("rst_idle", 4'd0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
